branch_resolve: RTL and testbench

Branch resolution unit: the execute-side counterpart of the fetch-stage 2-bit branch predictor. Records every prediction issued at fetch in an in-order queue and checks each one against the actual outcome when the branch resolves in execute. Emits the training signal that drives the predictor's `phit` input, a one-cycle flush with the corrected PC on misprediction, and saturating branch/mispredict statistics. Sits between the fetch and execute stages of the pipelined datapath.

---
 rtl/cpu_types_pkg.sv | 8 +
 rtl/dp_types_pkg.sv | 12 +
 rtl/bres_fifo.sv | 50 +++++
 rtl/branch_resolve.sv | 82 ++++++++
 tb/tb_branch_resolve.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Core CPU-wide scalar types shared across the datapath.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/dp_types_pkg.sv
// Datapath record types; bres_entry_t is one in-flight branch prediction.
package dp_types_pkg;

  import cpu_types_pkg::*;

  typedef struct packed {
    word_t pc;
    logic  taken;
    word_t npc;
  } bres_entry_t;

endpackage

// File: rtl/bres_fifo.sv
// In-order queue of outstanding branch predictions; clear beats push and pop.
module bres_fifo
  import dp_types_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  bres_entry_t din,
  output bres_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  bres_entry_t       mem [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [CW-1:0]     count;

  assign head  = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge CLK) begin
    if (push && !clear) mem[wptr] <= din;
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-side branch resolution: checks queued predictions against outcomes,
// trains the predictor, flushes on mispredict and keeps saturating statistics.
module branch_resolve
  import cpu_types_pkg::*;
  import dp_types_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             pred_valid,
  input  word_t            pred_pc,
  input  logic             pred_taken,
  input  word_t            pred_npc,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  input  word_t            res_target,
  output logic             upd_valid,
  output logic             upd_taken,
  output logic             flush,
  output word_t            redirect_pc,
  output logic             res_err,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  bres_entry_t head, din;
  logic        full, empty;
  logic        res_fire, mispred, push, pop;
  word_t       correct_npc;
  logic        unused_taken;

  assign din          = '{pc: pred_pc, taken: pred_taken, npc: pred_npc};
  assign pred_ready   = !full;
  assign unused_taken = head.taken;

  always_comb begin
    res_fire    = res_valid && !empty;
    correct_npc = res_taken ? res_target : head.pc + 32'd4;
    mispred     = res_fire && (head.npc != correct_npc);
    // Anything enqueued alongside or right after a mispredict is wrong-path.
    push        = pred_valid && pred_ready && !flush && !mispred;
    pop         = res_fire && !mispred;
  end

  bres_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .pop   (pop),
    .clear (mispred),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      upd_valid     <= 1'b0;
      upd_taken     <= 1'b0;
      flush         <= 1'b0;
      redirect_pc   <= '0;
      res_err       <= 1'b0;
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      upd_valid   <= res_fire;
      upd_taken   <= res_fire && res_taken;
      flush       <= mispred;
      redirect_pc <= mispred ? correct_npc : '0;
      res_err     <= res_valid && empty;
      if (res_fire && (br_count != '1)) br_count <= br_count + CNT_W'(1);
      if (mispred && (mispred_count != '1)) mispred_count <= mispred_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: directed vectors with hand-computed results.
module tb_branch_resolve;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 32;

  logic             CLK = 1'b0;
  logic             RST;
  logic             pred_valid, pred_taken, pred_ready;
  logic [31:0]      pred_pc, pred_npc;
  logic             res_valid, res_taken;
  logic [31:0]      res_target;
  logic             upd_valid, upd_taken, flush, res_err;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] br_count, mispred_count;

  typedef struct packed {
    logic        uv;
    logic        ut;
    logic        fl;
    logic [31:0] rpc;
    logic        err;
    logic [31:0] bc;
    logic [31:0] mc;
  } out_t;

  out_t exp_q[$];
  int   cyc_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  branch_resolve #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .pred_valid    (pred_valid),
    .pred_pc       (pred_pc),
    .pred_taken    (pred_taken),
    .pred_npc      (pred_npc),
    .pred_ready    (pred_ready),
    .res_valid     (res_valid),
    .res_taken     (res_taken),
    .res_target    (res_target),
    .upd_valid     (upd_valid),
    .upd_taken     (upd_taken),
    .flush         (flush),
    .redirect_pc   (redirect_pc),
    .res_err       (res_err),
    .br_count      (br_count),
    .mispred_count (mispred_count)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic out_t mk(input logic uv, input logic ut, input logic fl,
                              input logic [31:0] rpc, input logic err,
                              input logic [31:0] bc, input logic [31:0] mc);
    mk = '{uv: uv, ut: ut, fl: fl, rpc: rpc, err: err, bc: bc, mc: mc};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // One cycle of stimulus; a resolve registers its expected response.
  task automatic step(input logic pv, input logic [31:0] ppc, input logic pt,
                      input logic [31:0] pnpc, input logic rv, input logic rt,
                      input logic [31:0] rtgt, input out_t e);
    pred_valid = pv;
    pred_pc    = ppc;
    pred_taken = pt;
    pred_npc   = pnpc;
    res_valid  = rv;
    res_taken  = rt;
    res_target = rtgt;
    if (rv) begin
      exp_q.push_back(e);
      cyc_q.push_back(cyc + 1);
    end
    @(posedge CLK);
    #1;
    pred_valid = 1'b0;
    res_valid  = 1'b0;
  endtask

  task automatic pred(input logic [31:0] pc, input logic t, input logic [31:0] npc);
    step(1'b1, pc, t, npc, 1'b0, 1'b0, 32'h0, '0);
  endtask

  task automatic res(input logic t, input logic [31:0] tgt, input out_t e);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, t, tgt, e);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, '0);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_pred_ready"}, 32'(pred_ready), 32'd1);
    check({tag, "_upd_valid"}, 32'(upd_valid), 32'd0);
    check({tag, "_upd_taken"}, 32'(upd_taken), 32'd0);
    check({tag, "_flush"}, 32'(flush), 32'd0);
    check({tag, "_redirect_pc"}, redirect_pc, 32'd0);
    check({tag, "_res_err"}, 32'(res_err), 32'd0);
    check({tag, "_br_count"}, br_count, 32'd0);
    check({tag, "_mispred_count"}, mispred_count, 32'd0);
  endtask

  // Monitor: every visible output event is matched against the oldest expectation.
  always @(negedge CLK) begin
    out_t got, e;
    int   c;
    if (upd_valid || flush || res_err) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: cycle %0d uv=%b fl=%b err=%b, none expected",
                 cyc, upd_valid, flush, res_err);
      end else begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("out_cycle", cyc, c);
        got = mk(upd_valid, upd_taken & e.uv, flush, redirect_pc & {32{e.fl}}, res_err,
                 br_count, mispred_count);
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL resolve_out: got uv=%b ut=%b fl=%b rpc=%h err=%b bc=%0d mc=%0d expected uv=%b ut=%b fl=%b rpc=%h err=%b bc=%0d mc=%0d",
                   got.uv, got.ut, got.fl, got.rpc, got.err, got.bc, got.mc,
                   e.uv, e.ut, e.fl, e.rpc, e.err, e.bc, e.mc);
        end
      end
    end
  end

  initial begin
    RST = 1'b1;
    pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0; pred_npc = '0;
    res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk_reset("reset");

    // Empty-queue resolve.
    res(1'b0, 32'h0, mk(0, 0, 0, 32'h0, 1, 0, 0));

    // Correct not-taken.
    pred(32'h100, 1'b0, 32'h104);
    res(1'b0, 32'h0, mk(1, 0, 0, 32'h0, 0, 1, 0));

    // Direction mispredict; resolve during flush sees an empty queue.
    pred(32'h200, 1'b0, 32'h204);
    res(1'b1, 32'h300, mk(1, 1, 1, 32'h300, 0, 2, 1));
    res(1'b0, 32'h0, mk(0, 0, 0, 32'h0, 1, 2, 1));

    // Right direction, wrong target; enqueue during flush is dropped.
    pred(32'h400, 1'b1, 32'h500);
    res(1'b1, 32'h540, mk(1, 1, 1, 32'h540, 0, 3, 2));
    pred(32'h700, 1'b0, 32'h704);
    res(1'b0, 32'h0, mk(0, 0, 0, 32'h0, 1, 3, 2));

    // Correct taken.
    pred(32'h600, 1'b1, 32'h640);
    res(1'b1, 32'h640, mk(1, 1, 0, 32'h0, 0, 4, 2));

    // Fill to DEPTH; fifth prediction refused even with a same-cycle resolve.
    for (int i = 0; i < 4; i++) pred(32'h1000 + 32'(i * 16), 1'b0, 32'h1004 + 32'(i * 16));
    check("full_pred_ready", 32'(pred_ready), 32'd0);
    step(1'b1, 32'h2000, 1'b0, 32'h2004, 1'b1, 1'b0, 32'h0, mk(1, 0, 0, 32'h0, 0, 5, 2));
    check("after_full_pred_ready", 32'(pred_ready), 32'd1);
    for (int i = 0; i < 3; i++) res(1'b0, 32'h0, mk(1, 0, 0, 32'h0, 0, 32'(6 + i), 2));
    res(1'b0, 32'h0, mk(0, 0, 0, 32'h0, 1, 8, 2));

    // Enqueue with correct resolve, then mispredict squashes everything.
    pred(32'h3000, 1'b0, 32'h3004);
    pred(32'h3010, 1'b0, 32'h3014);
    pred(32'h3020, 1'b0, 32'h3024);
    step(1'b1, 32'h3030, 1'b0, 32'h3034, 1'b1, 1'b0, 32'h0, mk(1, 0, 0, 32'h0, 0, 9, 2));
    check("enq_deq_pred_ready", 32'(pred_ready), 32'd1);
    step(1'b1, 32'h3040, 1'b0, 32'h3044, 1'b1, 1'b1, 32'h3100,
         mk(1, 1, 1, 32'h3100, 0, 10, 3));
    res(1'b0, 32'h0, mk(0, 0, 0, 32'h0, 1, 10, 3));

    // Reset with entries queued and an update pulse pending.
    pred(32'h4000, 1'b0, 32'h4004);
    pred(32'h4010, 1'b0, 32'h4014);
    pred(32'h4020, 1'b0, 32'h4024);
    res(1'b0, 32'h0, mk(1, 0, 0, 32'h0, 0, 11, 3));
    RST = 1'b1;
    idle();
    RST = 1'b0;
    chk_reset("midrst");
    res(1'b0, 32'h0, mk(0, 0, 0, 32'h0, 1, 0, 0));

    repeat (3) idle();
    check("pending_expectations", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
